// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive bit timer
package uart_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int MIN_PRESCALE  = 4;
    localparam int DEF_PRESCALE  = 8;
    localparam int DEF_DATA_LEN  = 8;
    localparam int MIN_DATA_LEN  = 5;
    localparam int MAX_DATA_LEN  = 9;
    localparam int MAX_FRAME_LEN = 13;

endpackage

// File: rtl/uart_rx_cfg_latch.sv
// rtl/uart_rx_cfg_latch.sv - clamps frame configuration and holds it for the duration of a frame
module uart_rx_cfg_latch #(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [3:0]         data_len,
    input  logic               par_en,
    input  logic               stop2,
    output logic [PRESC_W-1:0] in_p_m1,
    output logic [PRESC_W-1:0] in_mid,
    output logic [BIT_W-1:0]   in_l_m1,
    output logic [PRESC_W-1:0] p_m1,
    output logic [PRESC_W-1:0] mid,
    output logic [BIT_W-1:0]   l_m1
);
    import uart_pkg::*;

    logic [PRESC_W-1:0] p_clamp;
    logic [3:0]         d_clamp;

    // The in_* values are the clamped incoming config, used for decode while idle.
    always_comb begin
        p_clamp = (prescale < PRESC_W'(MIN_PRESCALE)) ? PRESC_W'(MIN_PRESCALE) : prescale;
        d_clamp = (data_len < 4'(MIN_DATA_LEN) || data_len > 4'(MAX_DATA_LEN))
                  ? 4'(DEF_DATA_LEN) : data_len;
        in_p_m1 = p_clamp - PRESC_W'(1);
        in_mid  = p_clamp >> 1;
        in_l_m1 = BIT_W'(d_clamp) + BIT_W'(par_en) + BIT_W'(stop2) + BIT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_m1 <= PRESC_W'(DEF_PRESCALE - 1);
            mid  <= PRESC_W'(DEF_PRESCALE / 2);
            l_m1 <= BIT_W'(DEF_DATA_LEN + 1);
        end else if (load) begin
            p_m1 <= in_p_m1;
            mid  <= in_mid;
            l_m1 <= in_l_m1;
        end
    end

endmodule

// File: rtl/uart_rx_bit_timer.sv
// rtl/uart_rx_bit_timer.sv - oversampling bit/frame timer with mid-bit sample strobes
module uart_rx_bit_timer #(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               restart,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [3:0]         data_len,
    input  logic               par_en,
    input  logic               stop2,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic [2:0]         samp_strb,
    output logic               bit_done,
    output logic               frame_done,
    output logic               busy
);
    import uart_pkg::*;

    state_t             state;
    logic               load;
    logic [PRESC_W-1:0] in_p_m1, in_mid, p_m1, mid;
    logic [BIT_W-1:0]   in_l_m1, l_m1;
    logic [PRESC_W-1:0] cur_p_m1, cur_mid;
    logic [BIT_W-1:0]   cur_l_m1;
    logic               last_edge, last_bit;

    assign load = (state == IDLE) && en && !restart;
    assign busy = (state == COUNT);

    uart_rx_cfg_latch #(
        .PRESC_W (PRESC_W),
        .BIT_W   (BIT_W)
    ) u_cfg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .prescale (prescale),
        .data_len (data_len),
        .par_en   (par_en),
        .stop2    (stop2),
        .in_p_m1  (in_p_m1),
        .in_mid   (in_mid),
        .in_l_m1  (in_l_m1),
        .p_m1     (p_m1),
        .mid      (mid),
        .l_m1     (l_m1)
    );

    // Idle is edge 0 of the next frame, so decode against the config about to be latched.
    always_comb begin
        cur_p_m1     = (state == IDLE) ? in_p_m1 : p_m1;
        cur_mid      = (state == IDLE) ? in_mid  : mid;
        cur_l_m1     = (state == IDLE) ? in_l_m1 : l_m1;
        last_edge    = (edge_cnt == cur_p_m1);
        last_bit     = (bit_cnt == cur_l_m1);
        samp_strb[0] = en && (edge_cnt == cur_mid - PRESC_W'(1));
        samp_strb[1] = en && (edge_cnt == cur_mid);
        samp_strb[2] = en && (edge_cnt == cur_mid + PRESC_W'(1));
        bit_done     = en && last_edge;
        frame_done   = bit_done && last_bit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (restart) begin
            state    <= IDLE;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (en) begin
            if (state == IDLE) begin
                state    <= COUNT;
                edge_cnt <= PRESC_W'(1);
            end else if (last_edge) begin
                edge_cnt <= '0;
                if (last_bit) begin
                    bit_cnt <= '0;
                    state   <= IDLE;
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end else begin
                edge_cnt <= edge_cnt + PRESC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// tb/tb_uart_rx_bit_timer.sv - self-checking bench for uart_rx_bit_timer against a frame-position model
module tb_uart_rx_bit_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       restart = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic [3:0] data_len = 4'd8;
    logic       par_en = 1'b0;
    logic       stop2 = 1'b0;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic [2:0] samp_strb;
    logic       bit_done, frame_done, busy;

    uart_rx_bit_timer #(.PRESC_W(6), .BIT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .restart    (restart),
        .prescale   (prescale),
        .data_len   (data_len),
        .par_en     (par_en),
        .stop2      (stop2),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .samp_strb  (samp_strb),
        .bit_done   (bit_done),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: position in frame is a flat clock count t; edge = t mod P, bit = t div P.
    bit m_busy;
    int m_t, m_p, m_d, m_par, m_s2;
    int cyc = 0, n_bd = 0, n_fd = 0, last_fd_cyc = 0, fd_gap = 0, s;

    function automatic int clp(input int p);
        return (p < 4) ? 4 : p;
    endfunction

    function automatic int cld(input int d);
        return (d < 5 || d > 9) ? 8 : d;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_t = 0; m_p = 8; m_d = 8; m_par = 0; m_s2 = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        int pe, le, e_edge, e_bit, mid;
        logic [2:0] e_strb;
        logic e_bd, e_fd;
        @(negedge clk);
        pe = m_busy ? m_p : clp(int'(prescale));
        le = m_busy ? (2 + m_d + m_par + m_s2) : (2 + cld(int'(data_len)) + int'(par_en) + int'(stop2));
        e_edge = m_t % pe;
        e_bit  = m_t / pe;
        mid    = pe / 2;
        e_strb = en ? {e_edge == mid + 1, e_edge == mid, e_edge == mid - 1} : 3'b000;
        e_bd   = en && (e_edge == pe - 1);
        e_fd   = e_bd && (e_bit == le - 1);
        chk("edge_cnt", 32'(edge_cnt), e_edge);
        chk("bit_cnt", 32'(bit_cnt), e_bit);
        chk("samp_strb", 32'(samp_strb), 32'(e_strb));
        chk("bit_done", 32'(bit_done), 32'(e_bd));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("busy", 32'(busy), 32'(m_busy));
        if (bit_done === 1'b1) n_bd++;
        if (frame_done === 1'b1) begin
            n_fd++;
            fd_gap = cyc - last_fd_cyc;
            last_fd_cyc = cyc;
        end
        cyc++;
        @(posedge clk);
        if (restart) begin
            m_busy = 1'b0; m_t = 0;
        end else if (en) begin
            if (!m_busy) begin
                m_p = clp(int'(prescale)); m_d = cld(int'(data_len));
                m_par = int'(par_en); m_s2 = int'(stop2);
                m_busy = 1'b1; m_t = 1;
            end else begin
                m_t++;
                if (m_t == (2 + m_d + m_par + m_s2) * m_p) begin
                    m_t = 0; m_busy = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_edge", 32'(edge_cnt), 0);
        chk("rst_bit", 32'(bit_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b1;

        // 1: default 8N1, continuous frames of 80 clocks
        en = 1'b1;
        run(160);
        chk("t1_frames", n_fd, 2);
        chk("t1_gap", fd_gap, 80);

        // 2: P=16 D=7 parity, 2 stop; mid-frame prescale change only affects next frame
        prescale = 6'd16; data_len = 4'd7; par_en = 1'b1; stop2 = 1'b1;
        n_fd = 0; s = cyc;
        run(20);
        prescale = 6'd5;
        run(156);
        chk("t2_frames", n_fd, 1);
        chk("t2_frame_end", last_fd_cyc - s, 175);
        n_bd = 0;
        run(55);
        chk("t2_bits_p5", n_bd, 11);

        // 3: clamped config P=4 D=8
        prescale = 6'd2; data_len = 4'd12; par_en = 1'b0; stop2 = 1'b0;
        n_fd = 0; s = cyc;
        run(40);
        chk("t3_frames", n_fd, 1);
        chk("t3_frame_end", last_fd_cyc - s, 39);

        // 4: en low holds counters
        prescale = 6'd8; data_len = 4'd8;
        run(35);
        chk("t4_edge_pre", 32'(edge_cnt), 3);
        chk("t4_bit_pre", 32'(bit_cnt), 4);
        en = 1'b0;
        run(7);
        chk("t4_edge_hold", 32'(edge_cnt), 3);
        chk("t4_bit_hold", 32'(bit_cnt), 4);
        en = 1'b1;
        run(45);

        // 5: restart mid-frame
        run(50);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t5_edge", 32'(edge_cnt), 0);
        chk("t5_bit", 32'(bit_cnt), 0);
        chk("t5_busy", 32'(busy), 0);
        tick();
        chk("t5_relatch_edge", 32'(edge_cnt), 1);
        chk("t5_relatch_busy", 32'(busy), 1);
        run(79);

        // 6: async reset mid-frame
        run(21);
        chk("t6_edge_pre", 32'(edge_cnt), 5);
        chk("t6_bit_pre", 32'(bit_cnt), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_edge", 32'(edge_cnt), 0);
        chk("t6_bit", 32'(bit_cnt), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_bit_done", 32'(bit_done), 0);
        chk("t6_frame_done", 32'(frame_done), 0);
        model_reset();
        rst = 1'b1;
        run(30);

        // Randomized enables, restarts and config churn
        for (int i = 0; i < 2500; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) begin
                prescale = 6'($urandom_range(0, 40));
                data_len = 4'($urandom_range(0, 15));
                par_en   = 1'($urandom_range(0, 1));
                stop2    = 1'($urandom_range(0, 1));
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
